// File: rtl/comb_prim_pkg.sv
// Shared types and constants for the comb_prim detector self-test controller.
package comb_prim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] PRIME_MASK = 16'h28AC;
  localparam int          VEC_W      = 4;
  localparam int          ERR_W      = 5;

  // Error counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (v == {ERR_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/comb_prim_bist_if.sv
// Detector-side bus: the BIST drives a..d (a is the MSB) and reads back y.
interface comb_prim_bist_if;
  logic a;
  logic b;
  logic c;
  logic d;
  logic y;

  modport master (output a, output b, output c, output d, input y);
  modport slave  (input a, input b, input c, input d, output y);
endinterface

// File: rtl/comb_prim_vec_cnt.sv
// Vector counter (clear / increment, never wraps past N_VEC-1) plus the per-vector settle counter.
module comb_prim_vec_cnt
  import comb_prim_pkg::*;
#(
  parameter int N_VEC  = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vec_clr,
  input  logic             vec_inc,
  input  logic             set_clr,
  input  logic             set_inc,
  output logic [VEC_W-1:0] vec,
  output logic             vec_last,
  output logic             set_last
);

  localparam int                 SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [VEC_W-1:0]   LAST_VEC = VEC_W'(N_VEC - 1);
  localparam logic [SET_W-1:0]   LAST_SET = SET_W'(SETTLE - 1);

  logic [VEC_W-1:0] vec_r;
  logic [SET_W-1:0] settle_r;

  // Vector index register; holds at the last vector rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_r <= {VEC_W{1'b0}};
    end else if (vec_clr) begin
      vec_r <= {VEC_W{1'b0}};
    end else if (vec_inc && !vec_last) begin
      vec_r <= vec_r + {{(VEC_W-1){1'b0}}, 1'b1};
    end else begin
      vec_r <= vec_r;
    end
  end

  // Settle counter: counts cycles a vector has been held in DRIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_r <= {SET_W{1'b0}};
    end else if (set_clr) begin
      settle_r <= {SET_W{1'b0}};
    end else if (set_inc) begin
      settle_r <= settle_r + {{(SET_W-1){1'b0}}, 1'b1};
    end else begin
      settle_r <= settle_r;
    end
  end

  assign vec      = vec_r;
  assign vec_last = (vec_r == LAST_VEC);
  assign set_last = (settle_r == LAST_SET);

endmodule

// File: rtl/comb_prim_bist.sv
// Self-test controller for the 4-bit prime detector: sweeps vectors, checks y, reports results.
// Optional build macro COMB_PRIM_BIST_HALT_EN stops the sweep at the first mismatch.
module comb_prim_bist
  import comb_prim_pkg::*;
#(
  parameter int          N_VEC    = 16,
  parameter int          SETTLE   = 2,
  parameter logic [15:0] EXP_MASK = PRIME_MASK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  comb_prim_bist_if.master  det,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [VEC_W-1:0]  first_err_vec,
  output logic              first_err_valid
);

  state_t           state_r;
  state_t           state_s;
  logic [VEC_W-1:0] vec_s;
  logic             vec_last_s;
  logic             set_last_s;
  logic             vec_clr_s;
  logic             vec_inc_s;
  logic             set_clr_s;
  logic             set_inc_s;
  logic             mismatch_s;
  logic [ERR_W-1:0] err_s;
  logic [VEC_W-1:0] fev_s;
  logic             fvalid_s;

  comb_prim_vec_cnt #(
    .N_VEC  (N_VEC),
    .SETTLE (SETTLE)
  ) u_vec_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .vec_clr  (vec_clr_s),
    .vec_inc  (vec_inc_s),
    .set_clr  (set_clr_s),
    .set_inc  (set_inc_s),
    .vec      (vec_s),
    .vec_last (vec_last_s),
    .set_last (set_last_s)
  );

  // The counter output is already a register, so a..d are glitch-free.
  assign {det.a, det.b, det.c, det.d} = vec_s;

  // Next-state, counter control and next result values.
  always_comb begin
    state_s    = state_r;
    vec_clr_s  = 1'b0;
    vec_inc_s  = 1'b0;
    set_clr_s  = 1'b0;
    set_inc_s  = 1'b0;
    mismatch_s = 1'b0;
    err_s      = err_cnt;
    fev_s      = first_err_vec;
    fvalid_s   = first_err_valid;
    case (state_r)
      IDLE: begin
        vec_clr_s = 1'b1;
        set_clr_s = 1'b1;
        err_s     = {ERR_W{1'b0}};
        fev_s     = {VEC_W{1'b0}};
        fvalid_s  = 1'b0;
        if (start) begin
          state_s = DRIVE;
        end else begin
          state_s = IDLE;
        end
      end
      DRIVE: begin
        if (set_last_s) begin
          set_clr_s = 1'b1;
          state_s   = CHECK;
        end else begin
          set_inc_s = 1'b1;
        end
      end
      CHECK: begin
        mismatch_s = (det.y != EXP_MASK[vec_s]);
        if (mismatch_s) begin
          err_s = sat_inc(err_cnt);
          if (!first_err_valid) begin
            fev_s    = vec_s;
            fvalid_s = 1'b1;
          end else begin
            fvalid_s = first_err_valid;
          end
        end else begin
          err_s = err_cnt;
        end
`ifdef COMB_PRIM_BIST_HALT_EN
        if (mismatch_s || vec_last_s) begin
`else
        if (vec_last_s) begin
`endif
          state_s = DONE;
        end else begin
          vec_inc_s = 1'b1;
          state_s   = DRIVE;
        end
      end
      DONE: begin
        if (start) begin
          vec_clr_s = 1'b1;
          set_clr_s = 1'b1;
          err_s     = {ERR_W{1'b0}};
          fev_s     = {VEC_W{1'b0}};
          fvalid_s  = 1'b0;
          state_s   = DRIVE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered status/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= {ERR_W{1'b0}};
      first_err_vec   <= {VEC_W{1'b0}};
      first_err_valid <= 1'b0;
    end else begin
      state_r         <= state_s;
      busy            <= (state_s == DRIVE) || (state_s == CHECK);
      done            <= (state_s == DONE);
      pass            <= (state_s == DONE) && (err_s == {ERR_W{1'b0}});
      err_cnt         <= err_s;
      first_err_vec   <= fev_s;
      first_err_valid <= fvalid_s;
    end
  end

endmodule

// File: tb/tb_comb_prim_bist.sv
// Self-checking bench for comb_prim_bist: elapsed-time reference model plus directed literal checks.
module tb_comb_prim_bist;

  localparam int NV  = 16;
  localparam int ST  = 2;
  localparam int PER = ST + 1;
`ifdef COMB_PRIM_BIST_HALT_EN
  localparam int HALT = 1;
`else
  localparam int HALT = 0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass, fvalid;
  logic [4:0] err_cnt;
  logic [3:0] fev;

  int mode  = 0;   // 0 golden, 1 y=0, 2 y=~prime, 3 y=1
  int n_chk = 0;
  int n_pass = 0;
  int cyc   = 0;
  int t0    = 0;
  int phase = 0;   // model: 0 reset/idle, 1 sweep started
  int j     = 0;   // model: cycles since the start was accepted

  comb_prim_bist_if bus ();

  comb_prim_bist #(.N_VEC(NV), .SETTLE(ST), .EXP_MASK(16'h28AC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .det(bus),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_vec(fev), .first_err_valid(fvalid)
  );

  always #5 clk = ~clk;

  function automatic bit is_prime(input int v);
    if (v < 2) return 1'b0;
    for (int k = 2; k * k <= v; k++) if (v % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic y_of(input int m, input int v);
    case (m)
      0:       return is_prime(v);
      1:       return 1'b0;
      2:       return !is_prime(v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit mism(input int m, input int v);
    return (y_of(m, v) != is_prime(v));
  endfunction

  function automatic int stop_idx(input int m);
    if (HALT != 0) for (int v = 0; v < NV; v++) if (mism(m, v)) return v;
    return NV - 1;
  endfunction

  assign bus.y = y_of(mode, int'({bus.a, bus.b, bus.c, bus.d}));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model timeline: a start is accepted whenever no sweep is in progress.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0;
      j     <= 0;
    end else if (start && !(phase == 1 && j < (stop_idx(mode) + 1) * PER)) begin
      phase <= 1;
      j     <= 0;
    end else if (phase == 1) begin
      j <= j + 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int st, nchk, e_err, e_fev, e_fv, e_vec, e_busy, e_done;
    e_err = 0; e_fev = 0; e_fv = 0; e_vec = 0; e_busy = 0; e_done = 0; nchk = 0;
    if (phase == 1) begin
      st = stop_idx(mode);
      if (j >= (st + 1) * PER) begin
        e_done = 1; e_vec = st; nchk = st + 1;
      end else begin
        e_busy = 1; e_vec = j / PER; nchk = j / PER;
      end
      for (int v = 0; v < nchk; v++) begin
        if (mism(mode, v)) begin
          if (e_err < 31) e_err++;
          if (e_fv == 0) begin e_fv = 1; e_fev = v; end
        end
      end
    end
    chk("busy", int'(busy), e_busy);
    chk("done", int'(done), e_done);
    chk("pass", int'(pass), (e_done == 1 && e_err == 0) ? 1 : 0);
    chk("err_cnt", int'(err_cnt), e_err);
    chk("first_err_vec", int'(fev), e_fev);
    chk("first_err_valid", int'(fvalid), e_fv);
    chk("abcd", int'({bus.a, bus.b, bus.c, bus.d}), e_vec);
  end

  task automatic pulse(input int m, input bit mark);
    @(negedge clk); #1;
    mode  = m;
    start = 1'b1;
    if (mark) t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int lat;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin lat = cyc - t0; break; end
    end
    chk(name, lat, exp_lat);
  endtask

  task automatic results(input string name, input int e_err, input int e_fev, input int e_fv,
                         input int e_pass, input int e_vec);
    chk({name, "_err"},  int'(err_cnt), e_err);
    chk({name, "_fev"},  int'(fev), e_fev);
    chk({name, "_fv"},   int'(fvalid), e_fv);
    chk({name, "_pass"}, int'(pass), e_pass);
    chk({name, "_vec"},  int'({bus.a, bus.b, bus.c, bus.d}), e_vec);
  endtask

  initial begin
    logic [15:0] mask;
    int          hit;
    mask = 16'h0000;
    for (int v = 0; v < 16; v++) mask[v] = is_prime(v);
    chk("model_mask", int'(mask), 32'h28AC);

    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Golden detector: full clean sweep, done 49 cycles after the start cycle.
    pulse(0, 1'b1);
    wait_done("lat_golden", 49);
    results("golden", 0, 0, 0, 1, 15);

    // Faulty detector patterns.
    pulse(1, 1'b1);
    wait_done("lat_y0", HALT ? 10 : 49);
    results("y0", HALT ? 1 : 6, 2, 1, 0, HALT ? 2 : 15);
    pulse(2, 1'b1);
    wait_done("lat_ynot", HALT ? 4 : 49);
    results("ynot", HALT ? 1 : 16, 0, 1, 0, HALT ? 0 : 15);
    pulse(3, 1'b1);
    wait_done("lat_y1", HALT ? 4 : 49);
    results("y1", HALT ? 1 : 10, 0, 1, 0, HALT ? 0 : 15);

    // Reset asserted while vector 7 is on the bus.
    pulse(0, 1'b1);
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({bus.a, bus.b, bus.c, bus.d} == 4'd7) begin hit = 1; break; end
    end
    chk("reach_vec7", hit, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    results("rst", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    pulse(0, 1'b1);
    wait_done("lat_after_rst", 49);
    results("after_rst", 0, 0, 0, 1, 15);

    // Start while busy is ignored; start in DONE clears and re-sweeps.
    pulse(0, 1'b1);
    repeat (10) @(negedge clk);
    pulse(0, 1'b0);
    wait_done("lat_busy_start", 49);
    pulse(1, 1'b1);
    chk("restart_done", int'(done), 0);
    chk("restart_err", int'(err_cnt), 0);
    chk("restart_busy", int'(busy), 1);
    wait_done("lat_restart", HALT ? 10 : 49);
    results("restart", HALT ? 1 : 6, 2, 1, 0, HALT ? 2 : 15);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/comb_prim_bist.md
Name: comb_prim_bist

Overview:
- Sequential built-in self-test controller for the 4-bit prime detector (`comb_prim`: inputs A,B,C,D, output Y).
- Drives the detector's inputs through an exhaustive vector sweep and reads back Y on every vector.
- Compares each Y against an expected truth mask, then reports pass/fail, the mismatch count and the first failing vector.
- Acts as the hardware "reader" end of the detector interface; sits beside the detector instance at top level.

Parameters:
- N_VEC, 16, number of vectors swept starting at 4'b0000; legal range 1..16.
- SETTLE, 2, cycles a vector is held before Y is sampled; legal range ≥1.
- EXP_MASK, 16'h28AC, expected Y per vector index; bit i = 1 iff i is prime (2,3,5,7,11,13).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a sweep.
- a, b, c, d  output  1 each  detector inputs; {a,b,c,d} = vector, a is the MSB.
- y  input  1  detector output; combinational from a..d, same clock domain.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high in DONE until the next start.
- pass  output  1  valid when done; 1 iff err_cnt == 0.
- err_cnt  output  5  mismatch count, saturating at 31.
- first_err_vec  output  4  vector index of the first mismatch.
- first_err_valid  output  1  first_err_vec holds a captured value.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; {a,b,c,d} = 0.
  - busy, done, pass, first_err_valid = 0; err_cnt = 0; first_err_vec = 0.
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE:
  - start=1 → DRIVE.
  - Clears err_cnt, first_err_valid, first_err_vec, pass and the vector counter to 0.
- DRIVE:
  - Holds the current vector on a..d for SETTLE cycles via the settle counter, then → CHECK.
- CHECK, one cycle:
  - Compare y with EXP_MASK[vec].
  - On mismatch, increment err_cnt (saturating).
  - If first_err_valid == 0 on a mismatch, capture first_err_vec = vec and set first_err_valid = 1.
  - If vec == N_VEC-1 → DONE; otherwise vec += 1 and → DRIVE.
  - The vector counter never wraps past N_VEC-1.
- DONE:
  - done = 1 and pass = (err_cnt == 0).
  - a..d keep the last vector.
  - start=1 → restart exactly as from IDLE (counters cleared, → DRIVE).
- busy = 1 in DRIVE and CHECK only.
- start is ignored while busy.
- Timing: with start high at cycle T (in IDLE), vector 0 appears at T+1 and done rises at T+1+N_VEC*(SETTLE+1). Defaults give T+49.
- Reset asserted mid-sweep aborts immediately to reset values; no partial result is kept.
- err_cnt width rule: 5 bits holds 16 without overflow; saturation logic is still required.

Optional Feature:
- Macro: COMB_PRIM_BIST_HALT_EN.
- Defined: the first mismatch in CHECK sends the FSM straight to DONE with err_cnt = 1, first_err_vec = failing vector and a..d held at that vector.
- Undefined: full sweep regardless of mismatches, as described in Behaviour.

Decomposition:
- Package comb_prim_pkg:
  - state enum {IDLE, DRIVE, CHECK, DONE}.
  - PRIME_MASK = 16'h28AC.
  - VEC_W = 4, ERR_W = 5.
- Sub-module comb_prim_vec_cnt:
  - Vector counter with clear, increment and last-vector flag.
  - Also holds the settle counter.
- FSM and checker stay in the top.

Test Plan:
- Golden `comb_prim` attached, start pulse at cycle 5 → done at cycle 54, pass=1, err_cnt=0, first_err_valid=0, a..d walk 0..15.
- y tied 0 → err_cnt=6, first_err_vec=4'd2, pass=0.
- y = ~prime → err_cnt=16, first_err_vec=0, pass=0; y tied 1 → err_cnt=10, first_err_vec=0.
- rst_n pulsed low at vector 7 → outputs back to reset values the same cycle; a following start runs a full clean sweep with pass=1.
- start pulsed while busy and again in DONE → first ignored (done still at the expected cycle); second clears results and re-sweeps.
- With COMB_PRIM_BIST_HALT_EN and y tied 0 → done after vector 2's CHECK, err_cnt=1, {a,b,c,d}=4'b0010.
